dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder serving the pipelined CPU core's DM request interface: single-ported word array with separate read and write addresses.
- Fixed configurable access latency, one-cycle completion strobe, and alignment checking.
- Sits between the core's MEM stage and the data-memory array, replacing the zero-latency behavioural memory.
- Allows the core's stall logic to be exercised against multi-cycle memory.

Parameters:
- DataSize, 32: data word width.
- AddrWidth, 12: byte-address width of DM_in_address and DM_out_address.
- memSize, 10: log2 of the number of words in the array.
- RdLatency, 1: cycles from read acceptance to completion; legal range 1..4.
- WrLatency, 1: cycles from write acceptance to completion; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- DM_enable_mem  input  1  request valid / chip enable.
- DM_enable_fetch  input  1  read request.
- DM_enable_write  input  1  write request.
- DM_in  input  DataSize  write data.
- DM_in_address  input  AddrWidth  write byte address.
- DM_out_address  input  AddrWidth  read byte address.
- DM_out  output  DataSize  read data, registered.
- DM_ready  output  1  one-cycle completion strobe.
- DM_busy  output  1  high while a request is in flight.
- DM_misalign  output  1  error qualifier, valid only with DM_ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - DM_out=0, DM_ready=0, DM_busy=0, DM_misalign=0, state=IDLE, latency counter=0, captured request cleared.
  - Array contents are not cleared.
  - Reset asserted mid-operation aborts the request; an uncompleted write is never committed.
- Addressing: word index = address[memSize+1:2]. Bits above memSize+1 are ignored, so addresses alias (wrap) modulo 2^(memSize+2).
- Misaligned request: address[1:0]!=0 on any address used by the request.
- States: IDLE, RD_WAIT, WR_WAIT, RW_WAIT.
- IDLE:
  - Request accepted at a rising edge when DM_enable_mem=1 and (DM_enable_fetch | DM_enable_write).
  - Captures both addresses, DM_in and the op type.
  - Loads counter: RdLatency for read, WrLatency for write, max(RdLatency, WrLatency) for combined.
  - DM_busy=1 from the acceptance edge.
  - Next state: RD_WAIT (fetch only), WR_WAIT (write only), RW_WAIT (both).
  - DM_enable_mem=0, or mem=1 with neither fetch nor write: no-op, stay IDLE.
- WAIT states:
  - Counter decrements each edge.
  - Inputs are ignored while busy; requests are neither queued nor errored.
  - The core must hold or re-present a request until it is accepted.
- Completion edge (counter reaches 1 -> 0):
  - Write commits array[word(DM_in_address)] = captured DM_in.
  - Read loads DM_out = array[word(DM_out_address)].
  - Combined op, same word: write first; DM_out returns the new data (write-through forwarding).
  - DM_ready=1 for exactly one cycle, DM_busy=0, return to IDLE.
- Latency: request accepted at edge N -> DM_ready high between edges N+L and N+L+1, where L is the applicable latency. DM_out is valid from edge N+L.
- Back-to-back: a new request may be accepted at the edge where DM_ready falls, giving a throughput of one request per L+1 cycles.
- Misaligned completion:
  - DM_ready=1 and DM_misalign=1 together.
  - No array write; DM_out keeps its previous value.
  - Applies to the whole combined op if either address is misaligned.
- DM_out holds its value between read completions; writes never alter DM_out except via the combined-op forwarding rule.

Test Plan:
- Reset with RdLatency=1: after rst 0->1, DM_out=0, DM_ready=0, DM_busy=0. Preload array[5]=0xDEADBEEF; read DM_out_address=0x014 -> DM_ready at edge N+1, DM_out=0xDEADBEEF.
- RdLatency=3, WrLatency=2: write 0x12345678 to 0x020; DM_ready exactly 2 cycles after acceptance. Then read 0x020 -> DM_ready 3 cycles after acceptance, DM_out=0x12345678. A second request presented while busy is ignored (array[9] unchanged).
- Combined op, both addresses 0x040, DM_in=0xA5A5A5A5, old array[16]=0x1 -> DM_out=0xA5A5A5A5 after max latency; array[16]=0xA5A5A5A5.
- Misaligned write to 0x022 with DM_in=0xFFFFFFFF -> DM_ready=1, DM_misalign=1; array[8] unchanged; DM_out unchanged.
- Reset mid-write with WrLatency=4: drop rst after 2 cycles -> array word unchanged, all outputs 0. Aliasing with memSize=8: write 0x404 aliases word 1, so a read of 0x004 returns the written data.

Source files
------------

// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - DM request/response bundle between the core MEM stage and the data-memory responder
//
// Groups the data-memory handshake so the core and the responder share one port.
//   master (core):      drives DM_enable_mem/fetch/write, DM_in, DM_in_address, DM_out_address
//                       and samples DM_out, DM_ready, DM_busy, DM_misalign
//   slave  (responder): the mirror image
interface dm_responder_if #(
    parameter int DataSize  = 32,
    parameter int AddrWidth = 12
);
    logic                 DM_enable_mem;
    logic                 DM_enable_fetch;
    logic                 DM_enable_write;
    logic [DataSize-1:0]  DM_in;
    logic [AddrWidth-1:0] DM_in_address;
    logic [AddrWidth-1:0] DM_out_address;
    logic [DataSize-1:0]  DM_out;
    logic                 DM_ready;
    logic                 DM_busy;
    logic                 DM_misalign;

    modport master (
        output DM_enable_mem, DM_enable_fetch, DM_enable_write,
        output DM_in, DM_in_address, DM_out_address,
        input  DM_out, DM_ready, DM_busy, DM_misalign
    );

    modport slave (
        input  DM_enable_mem, DM_enable_fetch, DM_enable_write,
        input  DM_in, DM_in_address, DM_out_address,
        output DM_out, DM_ready, DM_busy, DM_misalign
    );
endinterface

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - fixed-latency data-memory responder with alignment checking
//
// Single-ported word array behind the core's DM request interface. One request
// (read, write or combined) is accepted while idle, completes after a fixed
// latency with a one-cycle DM_ready strobe, and is flagged via DM_misalign if
// any address it uses is not word aligned.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   dm    : dm_responder_if.slave - request inputs, DM_out/DM_ready/DM_busy/DM_misalign outputs
module dm_responder #(
    parameter int DataSize  = 32,
    parameter int AddrWidth = 12,
    parameter int memSize   = 10,
    parameter int RdLatency = 1,
    parameter int WrLatency = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dm_responder_if.slave        dm
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RW_WAIT} state_t;

    localparam int         Words = 1 << memSize;
    localparam logic [2:0] RdLat = 3'(RdLatency);
    localparam logic [2:0] WrLat = 3'(WrLatency);
    localparam logic [2:0] RwLat = (RdLatency > WrLatency) ? RdLat : WrLat;

    logic [DataSize-1:0] mem [Words];

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    // Only the bits that select a word (plus the alignment bits) are kept;
    // higher address bits alias by construction.
    logic [memSize+1:0]  rd_addr_q, rd_addr_d;
    logic [memSize+1:0]  wr_addr_q, wr_addr_d;
    logic [DataSize-1:0] wdata_q, wdata_d;
    logic [DataSize-1:0] out_q, out_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                misalign_q, misalign_d;

    logic [memSize-1:0]  rd_idx, wr_idx;
    logic                is_rd, is_wr, done, mis, mem_we;
    logic [DataSize-1:0] rd_word;

    assign rd_idx = rd_addr_q[memSize+1:2];
    assign wr_idx = wr_addr_q[memSize+1:2];
    assign is_rd  = (state_q == RD_WAIT) || (state_q == RW_WAIT);
    assign is_wr  = (state_q == WR_WAIT) || (state_q == RW_WAIT);
    assign done   = (state_q != IDLE) && (cnt_q == 3'd1);
    // A misaligned address anywhere in the request poisons the whole request.
    assign mis    = (is_rd && (rd_addr_q[1:0] != 2'b00)) ||
                    (is_wr && (wr_addr_q[1:0] != 2'b00));
    // Writes commit only on the completion edge, so a reset before then
    // (which forces state_q to IDLE) leaves the array untouched.
    assign mem_we = done && is_wr && !mis;
    // Combined op to the same word returns the data being written.
    assign rd_word = (is_wr && (wr_idx == rd_idx)) ? wdata_q : mem[rd_idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wdata_d    = wdata_q;
        out_d      = out_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm.DM_enable_mem && (dm.DM_enable_fetch || dm.DM_enable_write)) begin
                    rd_addr_d = dm.DM_out_address[memSize+1:0];
                    wr_addr_d = dm.DM_in_address[memSize+1:0];
                    wdata_d   = dm.DM_in;
                    busy_d    = 1'b1;
                    if (dm.DM_enable_fetch && dm.DM_enable_write) begin
                        state_d = RW_WAIT;
                        cnt_d   = RwLat;
                    end else if (dm.DM_enable_fetch) begin
                        state_d = RD_WAIT;
                        cnt_d   = RdLat;
                    end else begin
                        state_d = WR_WAIT;
                        cnt_d   = WrLat;
                    end
                end
            end
            default: begin
                // Request inputs are deliberately ignored while waiting.
                if (done) begin
                    state_d    = IDLE;
                    cnt_d      = 3'd0;
                    busy_d     = 1'b0;
                    ready_d    = 1'b1;
                    misalign_d = mis;
                    if (is_rd && !mis) begin
                        out_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wdata_q    <= '0;
            out_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wdata_q    <= wdata_d;
            out_q      <= out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            misalign_q <= misalign_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= wdata_q;
        end
    end

    assign dm.DM_out      = out_q;
    assign dm.DM_ready    = ready_q;
    assign dm.DM_busy     = busy_q;
    assign dm.DM_misalign = misalign_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - randomized self-checking bench for dm_responder
module tb_dm_responder;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MS = 8;
    localparam int RL = 3;
    localparam int WL = 2;
    localparam int WORDS = 1 << MS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if #(.DataSize(DW), .AddrWidth(AW)) dm();

    dm_responder #(
        .DataSize(DW), .AddrWidth(AW), .memSize(MS),
        .RdLatency(RL), .WrLatency(WL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dm  (dm)
    );

    logic [31:0] model [int];
    logic [31:0] exp_out;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [AW-1:0] a);
        return (int'(a) / 4) % WORDS;
    endfunction

    task automatic idle_inputs();
        dm.DM_enable_mem   = 1'b0;
        dm.DM_enable_fetch = 1'b0;
        dm.DM_enable_write = 1'b0;
    endtask

    // Present one request, optionally try to sneak a second write in while
    // busy, then wait (bounded) for completion and check against the model.
    task automatic do_req(input bit f, input bit w, input logic [AW-1:0] ra,
                          input logic [AW-1:0] wa, input logic [31:0] wd, input bit inject);
        int lat;
        int cyc;
        bit mis;
        dm.DM_enable_mem   = 1'b1;
        dm.DM_enable_fetch = f;
        dm.DM_enable_write = w;
        dm.DM_out_address  = ra;
        dm.DM_in_address   = wa;
        dm.DM_in           = wd;
        @(posedge clk); #1;
        chk("busy_after_accept", 32'(dm.DM_busy), 32'd1);
        chk("ready_low_after_accept", 32'(dm.DM_ready), 32'd0);
        cyc = 0;
        if (inject) begin
            dm.DM_enable_fetch = 1'b0;
            dm.DM_enable_write = 1'b1;
            dm.DM_in_address   = wa ^ 12'h004;
            dm.DM_in           = ~wd;
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        while (!dm.DM_ready && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        lat = (f && w) ? ((RL > WL) ? RL : WL) : (f ? RL : WL);
        mis = (f && (ra % 4 != 0)) || (w && (wa % 4 != 0));
        if (!mis) begin
            if (w) model[word_of(wa)] = wd;
            if (f) exp_out = model[word_of(ra)];
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("misalign", 32'(dm.DM_misalign), 32'(mis));
        chk("dm_out", dm.DM_out, exp_out);
        chk("busy_at_ready", 32'(dm.DM_busy), 32'd0);
    endtask

    initial begin
        idle_inputs();
        dm.DM_in = '0;
        dm.DM_in_address = '0;
        dm.DM_out_address = '0;
        exp_out = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_out", dm.DM_out, 32'd0);
        chk("reset_ready", 32'(dm.DM_ready), 32'd0);
        chk("reset_busy", 32'(dm.DM_busy), 32'd0);
        chk("reset_misalign", 32'(dm.DM_misalign), 32'd0);

        // No-op requests must not start anything.
        dm.DM_enable_mem = 1'b1;
        @(posedge clk); #1;
        chk("noop_mem_only", 32'(dm.DM_busy), 32'd0);
        dm.DM_enable_mem = 1'b0;
        dm.DM_enable_fetch = 1'b1;
        dm.DM_enable_write = 1'b1;
        @(posedge clk); #1;
        chk("noop_no_mem", 32'(dm.DM_busy), 32'd0);
        idle_inputs();

        for (int i = 0; i < WORDS; i++)
            do_req(1'b0, 1'b1, '0, AW'(i * 4), $urandom, 1'b0);

        do_req(1'b0, 1'b1, '0, 12'h014, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 1'b0, 12'h014, '0, '0, 1'b0);
        chk("read_deadbeef", dm.DM_out, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, '0, 12'h020, 32'h12345678, 1'b1);
        do_req(1'b1, 1'b0, 12'h020, '0, '0, 1'b0);
        do_req(1'b1, 1'b0, 12'h024, '0, '0, 1'b0);

        do_req(1'b0, 1'b1, '0, 12'h040, 32'h00000001, 1'b0);
        do_req(1'b1, 1'b1, 12'h040, 12'h040, 32'hA5A5A5A5, 1'b0);
        chk("combined_forward", dm.DM_out, 32'hA5A5A5A5);
        do_req(1'b1, 1'b0, 12'h040, '0, '0, 1'b0);

        do_req(1'b0, 1'b1, '0, 12'h022, 32'hFFFFFFFF, 1'b0);
        do_req(1'b1, 1'b0, 12'h020, '0, '0, 1'b0);

        do_req(1'b0, 1'b1, '0, 12'h404, 32'hCAFEF00D, 1'b0);
        do_req(1'b1, 1'b0, 12'h004, '0, '0, 1'b0);
        chk("alias_read", dm.DM_out, 32'hCAFEF00D);

        // Reset in the middle of a write: write must not commit.
        dm.DM_enable_mem   = 1'b1;
        dm.DM_enable_write = 1'b1;
        dm.DM_in_address   = 12'h00C;
        dm.DM_in           = 32'h55AA55AA ^ model[3];
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        exp_out = '0;
        #1;
        chk("midrst_out", dm.DM_out, 32'd0);
        chk("midrst_busy", 32'(dm.DM_busy), 32'd0);
        chk("midrst_ready", 32'(dm.DM_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_req(1'b1, 1'b0, 12'h00C, '0, '0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            bit f, w;
            logic [AW-1:0] ra, wa;
            f  = 1'($urandom);
            w  = 1'($urandom);
            if (!f && !w) f = 1'b1;
            ra = AW'($urandom);
            wa = AW'($urandom);
            if ($urandom_range(3) != 0) ra[1:0] = 2'b00;
            if ($urandom_range(3) != 0) wa[1:0] = 2'b00;
            if ($urandom_range(3) == 0) ra = wa;
            do_req(f, w, ra, wa, $urandom, $urandom_range(3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
